// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table,
// blank/off codes and the polarity helper used on the pin side.
package seg7_pkg;

    // Active-high glyphs, bit0 = segment A ... bit6 = segment G.
    // Entry 15 (F) is the leftmost element, entry 0 (digit 0) the rightmost.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h71,  // F: A E F G
        7'h79,  // E: A D E F G
        7'h5E,  // d: B C D E G
        7'h39,  // C: A D E F
        7'h7C,  // b: C D E F G
        7'h77,  // A: A B C E F G
        7'h67,  // 9: A B C F G
        7'h7F,  // 8: all segments
        7'h07,  // 7: A B C
        7'h7D,  // 6: A C D E F G
        7'h6D,  // 5: A C D F G
        7'h66,  // 4: B C F G
        7'h4F,  // 3: A B C D G
        7'h5B,  // 2: A B D E G
        7'h06,  // 1: B C
        7'h3F   // 0: A B C D E F
    };

    // Glyph shown by a dark digit (nothing lit), active-high.
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    // {dp, seg} with nothing lit, active-high.
    localparam logic [7:0] SEG_OFF = 8'h00;

    // Converts an active-high {dp, seg} pattern to the board's pin polarity.
    function automatic logic [7:0] apply_polarity(input logic [7:0] lit, input bit active_low);
        return active_low ? ~lit : lit;
    endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational hex nibble to active-high seven-segment glyph lookup.
module seg7_glyph_rom
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    // Pure table lookup; polarity and registering are left to the caller.
    always_comb begin
        glyph = GLYPH_TABLE[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with tear-free frame
// updates, per-digit blanking, leading-zero suppression and anti-ghosting.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic                      load,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic                      lz_blank,
    output logic [6:0]                seg,
    output logic                      seg_dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] BLANK_END = PRE_W'(BLANK_CYCLES);

    localparam bit SEG_LOW = (SEG_ACTIVE_LOW != 0);
    localparam bit DIG_LOW = (DIG_ACTIVE_LOW != 0);

    logic [PRE_W-1:0]          prescaler;
    logic [IDX_W-1:0]          idx;
    logic                      slot_end;
    logic                      frame_end;

    logic [4*NUM_DIGITS-1:0]   pend_value;
    logic [NUM_DIGITS-1:0]     pend_dp;
    logic [NUM_DIGITS-1:0]     pend_blank;
    logic                      pend_valid;

    logic [4*NUM_DIGITS-1:0]   act_value;
    logic [NUM_DIGITS-1:0]     act_dp;
    logic [NUM_DIGITS-1:0]     act_blank;

    logic [NUM_DIGITS-1:0]     upper_zero;
    logic [NUM_DIGITS-1:0]     dark_vec;
    logic [3:0]                cur_nibble;
    logic [6:0]                glyph;
    logic                      dark_now;
    logic                      dark_hold;
    logic                      in_blank;
    logic                      slot_dark;
    logic [6:0]                lit_segs;
    logic                      lit_dp;
    logic [NUM_DIGITS-1:0]     an_lit;

    assign slot_end  = (prescaler == PRE_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Slot prescaler: counts 0..CLK_DIV-1 and wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
        end else if (slot_end) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Digit index: steps once per slot and wraps after the last digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
        end else if (slot_end) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // Pending/active registers: loads park in pending, active only changes
    // at the frame boundary, and a load in the boundary cycle goes straight
    // to active without being left pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
            act_value  <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
        end else if (frame_end) begin
            if (load) begin
                act_value <= value;
                act_dp    <= dp_in;
                act_blank <= blank_mask;
            end else if (pend_valid) begin
                act_value <= pend_value;
                act_dp    <= pend_dp;
                act_blank <= pend_blank;
            end
            pend_valid <= 1'b0;
        end else if (load) begin
            pend_value <= value;
            pend_dp    <= dp_in;
            pend_blank <= blank_mask;
            pend_valid <= 1'b1;
        end
    end

    // Frame-completion pulse, one cycle after the wrap back to digit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
        end
    end

    // Which digits are dark: forced by mask, or a leading zero when
    // suppression is on (digit 0 always stays visible).
    always_comb begin
        logic run;
        run        = 1'b1;
        upper_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run           = run && (act_value[4*k +: 4] == 4'h0);
            upper_zero[k] = run && (k != 0);
        end
        dark_vec = act_blank | (lz_blank ? upper_zero : '0);
    end

    assign cur_nibble = act_value[int'(idx) * 4 +: 4];
    assign dark_now   = dark_vec[idx];
    assign in_blank   = (prescaler < BLANK_END) || (prescaler == '0);

    seg7_glyph_rom u_glyph_rom (
        .nibble (cur_nibble),
        .glyph  (glyph)
    );

    // Darkness decision is frozen after the blanking window so a live
    // lz_blank change cannot alter seg or an while the digit is lit.
    always_ff @(posedge clk) begin
        if (reset) begin
            dark_hold <= 1'b0;
        end else if (in_blank) begin
            dark_hold <= dark_now;
        end
    end

    // Next values for the registered pins, in active-high form.
    always_comb begin
        slot_dark = in_blank ? dark_now : dark_hold;
        lit_segs  = slot_dark ? GLYPH_BLANK : glyph;
        lit_dp    = act_dp[idx] && !slot_dark;
        an_lit    = '0;
        if ((prescaler >= BLANK_END) && !slot_dark) begin
            an_lit[idx] = 1'b1;
        end
    end

    // Segment pins only move inside the blanking window of a slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            {seg_dp, seg} <= apply_polarity(SEG_OFF, SEG_LOW);
        end else if (in_blank) begin
            {seg_dp, seg} <= apply_polarity({lit_dp, lit_segs}, SEG_LOW);
        end
    end

    // Digit enable pins, registered with pin polarity applied.
    always_ff @(posedge clk) begin
        if (reset) begin
            an <= DIG_LOW ? '1 : '0;
        end else begin
            an <= DIG_LOW ? ~an_lit : an_lit;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (4 digits, 8-cycle
// slots, 2 blanking cycles, active-low pins).
module tb_seg7_scan_driver;

    logic        clk;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_in;
    logic [3:0]  blank_mask;
    logic        lz_blank;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  an;
    logic        frame_done;

    int checks;
    int errors;

    int         on_cnt   [4];
    logic [6:0] seg_slot [4];
    logic       dp_slot  [4];
    int         fd_cnt;
    int         glitch_cnt;
    int         multi_cnt;
    logic       fd_last;

    seg7_scan_driver #(
        .NUM_DIGITS     (4),
        .CLK_DIV        (8),
        .BLANK_CYCLES   (2),
        .SEG_ACTIVE_LOW (1),
        .DIG_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .load       (load),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .seg_dp     (seg_dp),
        .an         (an),
        .frame_done (frame_done)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required end before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    // Counts one comparison and reports it if observed differs from expected.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one load strobe; caller is at a negedge, returns one negedge later.
    task automatic applyStimulus(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] mask);
        value      = v;
        dp_in      = dp;
        blank_mask = mask;
        load       = 1'b1;
        @(negedge clk);
        load       = 1'b0;
    endtask

    // Advances to the next negedge where frame_done is high, bounded.
    task automatic wait_frame(input string tag);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        if (!seen) checkOutput({tag, " frame timeout"}, 0, 1);
    endtask

    // Samples the 32 cycles after a frame start; sample i shows the state of
    // cycle i-1, so slot d owns samples 8d+1..8d+8.
    task automatic scan_frame();
        logic [6:0] prev_seg;
        prev_seg   = seg;
        fd_cnt     = 0;
        glitch_cnt = 0;
        multi_cnt  = 0;
        for (int d = 0; d < 4; d++) on_cnt[d] = 0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) if (an[d] == 1'b0) on_cnt[d]++;
            if ($countones(~an) > 1) multi_cnt++;
            if (an != 4'hF && seg != prev_seg) glitch_cnt++;
            prev_seg = seg;
            if (((i - 1) % 8) == 4) begin
                seg_slot[(i - 1) / 8] = seg;
                dp_slot[(i - 1) / 8]  = seg_dp;
            end
            if (frame_done) fd_cnt++;
        end
        fd_last = frame_done;
    endtask

    // Compares one scanned frame against hand-computed per-digit values.
    task automatic check_frame(input string name,
                               input logic [6:0] e3, input logic [6:0] e2,
                               input logic [6:0] e1, input logic [6:0] e0,
                               input logic [3:0] edp, input logic [3:0] eon);
        logic [6:0] es [4];
        es[0] = e0; es[1] = e1; es[2] = e2; es[3] = e3;
        for (int d = 0; d < 4; d++) begin
            checkOutput($sformatf("%s seg d%0d", name, d), int'(seg_slot[d]), int'(es[d]));
            checkOutput($sformatf("%s dp d%0d", name, d), int'(dp_slot[d]), int'(edp[d]));
            checkOutput($sformatf("%s an_cycles d%0d", name, d), on_cnt[d], eon[d] ? 6 : 0);
        end
        checkOutput({name, " frame_done count"}, fd_cnt, 1);
        checkOutput({name, " frame_done at 32"}, int'(fd_last), 1);
        checkOutput({name, " seg change while lit"}, glitch_cnt, 0);
        checkOutput({name, " multiple an"}, multi_cnt, 0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        value      = '0;
        load       = 1'b0;
        dp_in      = '0;
        blank_mask = '0;
        lz_blank   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state.
        checkOutput("reset an", int'(an), 4'hF);
        checkOutput("reset seg", int'(seg), 7'h7F);
        checkOutput("reset seg_dp", int'(seg_dp), 1);
        checkOutput("reset frame_done", int'(frame_done), 0);

        // 1: basic glyphs, decimal point on digit 2.
        $display("[TB] test 1: value 12AF");
        applyStimulus(16'h12AF, 4'b0100, 4'b0000);
        wait_frame("t1");
        scan_frame();
        check_frame("t1", 7'h79, 7'h24, 7'h08, 7'h0E, 4'b1011, 4'b1111);

        // 2: leading-zero suppression.
        $display("[TB] test 2: leading zeros");
        lz_blank = 1'b1;
        applyStimulus(16'h0030, 4'b0000, 4'b0000);
        wait_frame("t2a");
        scan_frame();
        check_frame("t2a", 7'h7F, 7'h7F, 7'h30, 7'h40, 4'b1111, 4'b0011);
        applyStimulus(16'h0000, 4'b0000, 4'b0000);
        wait_frame("t2b");
        scan_frame();
        check_frame("t2b", 7'h7F, 7'h7F, 7'h7F, 7'h40, 4'b1111, 4'b0001);

        // 3: two loads mid-frame, last one wins at the boundary.
        $display("[TB] test 3: mid-frame loads");
        lz_blank = 1'b0;
        wait_frame("t3");
        fork
            scan_frame();
            begin
                repeat (9) @(negedge clk);
                applyStimulus(16'h5555, 4'b1111, 4'b0000);
                repeat (8) @(negedge clk);
                applyStimulus(16'h7777, 4'b0000, 4'b0000);
            end
        join
        check_frame("t3 old", 7'h40, 7'h40, 7'h40, 7'h40, 4'b1111, 4'b1111);
        scan_frame();
        check_frame("t3 new", 7'h78, 7'h78, 7'h78, 7'h78, 4'b1111, 4'b1111);

        // 4: load in the wrap cycle takes effect in the frame starting there.
        $display("[TB] test 4: load at wrap");
        repeat (31) @(negedge clk);
        applyStimulus(16'h9E0C, 4'b0000, 4'b0000);
        checkOutput("t4 frame_done", int'(frame_done), 1);
        checkOutput("t4 pend_valid", int'(dut.pend_valid), 0);
        scan_frame();
        check_frame("t4", 7'h18, 7'h06, 7'h40, 7'h46, 4'b1111, 4'b1111);

        // 5: blank mask on digits 3 and 1.
        $display("[TB] test 5: blank mask");
        applyStimulus(16'h8888, 4'b1111, 4'b1010);
        wait_frame("t5");
        scan_frame();
        check_frame("t5", 7'h7F, 7'h00, 7'h7F, 7'h00, 4'b1010, 4'b0101);

        // 6: reset mid-scan with data pending.
        $display("[TB] test 6: reset mid-scan");
        wait_frame("t6");
        repeat (19) @(negedge clk);
        applyStimulus(16'h4444, 4'b1111, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("t6 reset an", int'(an), 4'hF);
        checkOutput("t6 reset seg", int'(seg), 7'h7F);
        checkOutput("t6 reset seg_dp", int'(seg_dp), 1);
        checkOutput("t6 reset frame_done", int'(frame_done), 0);
        scan_frame();
        check_frame("t6 first", 7'h40, 7'h40, 7'h40, 7'h40, 4'b1111, 4'b1111);
        scan_frame();
        check_frame("t6 second", 7'h40, 7'h40, 7'h40, 7'h40, 4'b1111, 4'b1111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
